// File: rtl/alu_issue_ctrl.sv
// Serialized issue/writeback controller for the combinational ALU: one command
// in flight, condition evaluated against stored N/Z, single writeback beat out.
module alu_issue_ctrl #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_cond,
  input  logic [3:0]   in_op,
  input  logic [1:0]   in_shift,
  input  logic         in_s,
  input  logic [3:0]   in_rd,
  input  logic [n-1:0] in_a,
  input  logic [n-1:0] in_b,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [2:0]   alu_ctrl,
  input  logic [n-1:0] alu_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_we,
  output logic         out_err,
  output logic [3:0]   out_rd,
  output logic [n-1:0] out_result,
  output logic         flag_n,
  output logic         flag_z
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t     state;
  logic       lat_s;
  logic       lat_pass;
  logic       lat_illegal;
  logic [3:0] lat_rd;

  logic       cond_pass;
  logic       illegal;
  logic [2:0] ctrl_next;

  always_comb begin
    cond_pass = 1'b0;
    case (in_cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Illegal opcodes issue with ctrl 000 so the ALU still sees a defined code.
  always_comb begin
    ctrl_next = 3'b000;
    illegal   = 1'b0;
    case (in_op)
      4'b0000: ctrl_next = 3'b000;
      4'b1100: ctrl_next = 3'b001;
      4'b0001: ctrl_next = 3'b010;
      4'b0100: ctrl_next = 3'b011;
      4'b1101: begin
        case (in_shift)
          2'b00:   ctrl_next = 3'b101;
          2'b01:   ctrl_next = 3'b100;
          2'b10:   ctrl_next = 3'b110;
          default: ctrl_next = 3'b111;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_we      <= 1'b0;
      out_err     <= 1'b0;
      out_rd      <= '0;
      out_result  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= '0;
      flag_n      <= 1'b0;
      flag_z      <= 1'b0;
      lat_s       <= 1'b0;
      lat_pass    <= 1'b0;
      lat_illegal <= 1'b0;
      lat_rd      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            lat_s       <= in_s;
            lat_pass    <= cond_pass;
            lat_illegal <= illegal;
            lat_rd      <= in_rd;
            alu_a       <= in_a;
            alu_b       <= in_b;
            alu_ctrl    <= ctrl_next;
            in_ready    <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          out_result <= alu_result;
          out_we     <= lat_pass & ~lat_illegal;
          out_err    <= lat_illegal;
          out_rd     <= lat_rd;
          if (lat_s && lat_pass && !lat_illegal) begin
            flag_z <= (alu_result == '0);
            flag_n <= alu_result[n-1];
          end
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU stub on the
// alu_a/alu_b/alu_ctrl -> alu_result path.
module tb_alu_issue_ctrl;
  localparam int n = 32;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_cond;
  logic [3:0]   in_op;
  logic [1:0]   in_shift;
  logic         in_s;
  logic [3:0]   in_rd;
  logic [n-1:0] in_a;
  logic [n-1:0] in_b;
  logic [n-1:0] alu_a;
  logic [n-1:0] alu_b;
  logic [2:0]   alu_ctrl;
  logic [n-1:0] alu_result;
  logic         out_valid;
  logic         out_ready;
  logic         out_we;
  logic         out_err;
  logic [3:0]   out_rd;
  logic [n-1:0] out_result;
  logic         flag_n;
  logic         flag_z;

  typedef struct {
    logic [3:0]   rd;
    logic [n-1:0] result;
    logic         we;
    logic         err;
    logic         fn;
    logic         fz;
    logic [n-1:0] a;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad   = 0;
  logic tb_n = 1'b0;
  logic tb_z = 1'b0;

  alu_issue_ctrl #(.n(n)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_op(in_op), .in_shift(in_shift), .in_s(in_s),
    .in_rd(in_rd), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we),
    .out_err(out_err), .out_rd(out_rd), .out_result(out_result),
    .flag_n(flag_n), .flag_z(flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: alu_result = alu_a ^ alu_b;
      3'b011: alu_result = alu_a + alu_b;
      3'b100: alu_result = alu_a >> alu_b[4:0];
      3'b101: alu_result = alu_a << alu_b[4:0];
      3'b110: alu_result = $signed(alu_a) >>> alu_b[4:0];
      default: alu_result = ~alu_a;
    endcase
  end

  task automatic send(input logic [3:0] cond, input logic [3:0] op, input logic [1:0] sh,
                      input logic s, input logic [3:0] rd, input logic [n-1:0] a,
                      input logic [n-1:0] b, input logic [2:0] exp_ctrl,
                      input logic [n-1:0] exp_res, input logic exp_we, input logic exp_err,
                      input logic keep);
    beat_t e;
    int cnt;
    cnt = 0;
    in_cond = cond; in_op = op; in_shift = sh; in_s = s; in_rd = rd; in_a = a; in_b = b;
    in_valid = 1'b1;
    while (!in_ready && cnt < 8) begin
      @(posedge clk); #1; cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (alu_ctrl !== exp_ctrl) begin
      $display("FAIL alu_ctrl op=%b got=%b exp=%b", op, alu_ctrl, exp_ctrl); bad++;
    end
    total++;
    if (alu_a !== a || alu_b !== b) begin
      $display("FAIL operands got=%h/%h exp=%h/%h", alu_a, alu_b, a, b); bad++;
    end
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL issue_state in_ready=%b out_valid=%b exp=0/0", in_ready, out_valid); bad++;
    end
    if (keep) begin
      if (s && exp_we) begin
        tb_z = (exp_res == '0);
        tb_n = exp_res[n-1];
      end
      e.rd = rd; e.result = exp_res; e.we = exp_we; e.err = exp_err;
      e.fn = tb_n; e.fz = tb_z; e.a = a;
      sb.push_back(e);
    end
  endtask

  task automatic collect(input int hold);
    beat_t e;
    int cnt;
    logic [n-1:0] r0;
    cnt = 0;
    @(posedge clk); #1;
    while (!out_valid && cnt < 8) begin
      @(posedge clk); #1; cnt++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      $display("FAIL beat_timeout out_valid=%b exp=1", out_valid); bad++;
      return;
    end
    total++;
    if (cnt != 0) begin
      $display("FAIL latency extra_edges=%0d exp=0", cnt); bad++;
    end
    total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty size=0 exp>0"); bad++;
      return;
    end
    e = sb.pop_front();
    if (out_result !== e.result || out_rd !== e.rd || out_we !== e.we || out_err !== e.err) begin
      $display("FAIL beat got res=%h rd=%0d we=%b err=%b exp res=%h rd=%0d we=%b err=%b",
               out_result, out_rd, out_we, out_err, e.result, e.rd, e.we, e.err);
      bad++;
    end
    total++;
    if (in_ready !== 1'b0) begin
      $display("FAIL done_in_ready got=%b exp=0", in_ready); bad++;
    end
    r0 = out_result;
    if (hold > 0) begin
      in_cond = 4'b1110; in_op = 4'b0100; in_a = 32'h1234; in_b = 32'h1; in_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_result !== r0 || in_ready !== 1'b0) begin
        $display("FAIL hold cyc=%0d valid=%b res=%h in_ready=%b exp 1/%h/0",
                 i, out_valid, out_result, in_ready, r0);
        bad++;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL release valid=%b in_ready=%b exp 0/1", out_valid, in_ready); bad++;
    end
    total++;
    if (alu_a !== e.a) begin
      $display("FAIL no_early_accept alu_a=%h exp=%h", alu_a, e.a); bad++;
    end
    total++;
    if (flag_n !== e.fn || flag_z !== e.fz) begin
      $display("FAIL flags got N=%b Z=%b exp N=%b Z=%b", flag_n, flag_z, e.fn, e.fz); bad++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_cond = '0; in_op = '0; in_shift = '0; in_s = 1'b0; in_rd = '0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_we !== 1'b0 || out_err !== 1'b0 ||
        alu_ctrl !== 3'b000 || out_result !== '0 || flag_n !== 1'b0 || flag_z !== 1'b0) begin
      $display("FAIL reset in_ready=%b valid=%b we=%b err=%b ctrl=%b res=%h N=%b Z=%b exp 1/0/0/0/000/0/0/0",
               in_ready, out_valid, out_we, out_err, alu_ctrl, out_result, flag_n, flag_z);
      bad++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    send(4'b1110, 4'b0100, 2'b00, 1'b1, 4'd3, 32'd5, 32'd7, 3'b011, 32'd12, 1'b1, 1'b0, 1'b1);
    collect(0);
  endtask

  task automatic test_flags();
    send(4'b1110, 4'b0001, 2'b00, 1'b1, 4'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 3'b010, 32'h0, 1'b1, 1'b0, 1'b1);
    collect(0);
    send(4'b0000, 4'b0100, 2'b00, 1'b0, 4'd5, 32'd1, 32'd1, 3'b011, 32'd2, 1'b1, 1'b0, 1'b1);
    collect(0);
    send(4'b0001, 4'b0100, 2'b00, 1'b1, 4'd6, 32'd1, 32'd2, 3'b011, 32'd3, 1'b0, 1'b0, 1'b1);
    collect(0);
  endtask

  task automatic test_shift_cond();
    send(4'b1110, 4'b1101, 2'b10, 1'b1, 4'd2, 32'h80000000, 32'd4, 3'b110, 32'hF8000000, 1'b1, 1'b0, 1'b1);
    collect(0);
    send(4'b0100, 4'b1100, 2'b00, 1'b0, 4'd7, 32'hF0, 32'h0F, 3'b001, 32'hFF, 1'b1, 1'b0, 1'b1);
    collect(0);
    send(4'b0101, 4'b0000, 2'b00, 1'b1, 4'd8, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
    collect(0);
    send(4'b1110, 4'b1101, 2'b00, 1'b0, 4'd9, 32'h1, 32'd8, 3'b101, 32'h100, 1'b1, 1'b0, 1'b1);
    collect(0);
    send(4'b1110, 4'b1101, 2'b01, 1'b0, 4'd10, 32'h100, 32'd4, 3'b100, 32'h10, 1'b1, 1'b0, 1'b1);
    collect(0);
    send(4'b0010, 4'b0000, 2'b00, 1'b1, 4'd11, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
    collect(0);
  endtask

  task automatic test_illegal();
    send(4'b1110, 4'b0010, 2'b00, 1'b1, 4'd12, 32'd3, 32'd1, 3'b000, 32'd1, 1'b0, 1'b1, 1'b1);
    collect(0);
  endtask

  task automatic test_backpressure();
    send(4'b1110, 4'b0100, 2'b00, 1'b0, 4'd13, 32'd100, 32'd23, 3'b011, 32'd123, 1'b1, 1'b0, 1'b1);
    collect(5);
  endtask

  task automatic test_reset_abort();
    int seen;
    seen = 0;
    send(4'b1110, 4'b0100, 2'b00, 1'b1, 4'd14, 32'd9, 32'd9, 3'b011, 32'd18, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_ctrl !== 3'b000 || alu_a !== '0 ||
        flag_n !== 1'b0 || flag_z !== 1'b0) begin
      $display("FAIL abort_reset in_ready=%b valid=%b ctrl=%b a=%h N=%b Z=%b exp 1/0/000/0/0/0",
               in_ready, out_valid, alu_ctrl, alu_a, flag_n, flag_z);
      bad++;
    end
    tb_n = 1'b0; tb_z = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      $display("FAIL abort_no_beat beats=%0d exp=0", seen); bad++;
    end
    send(4'b1110, 4'b0100, 2'b00, 1'b1, 4'd15, 32'd2, 32'd3, 3'b011, 32'd5, 1'b1, 1'b0, 1'b1);
    collect(0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_flags();
    test_shift_cond();
    test_illegal();
    test_backpressure();
    test_reset_abort();
    total++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_leftover size=%0d exp=0", sb.size()); bad++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
